dmem_arbiter: RTL and testbench

Shares the single-port, word-indexed data memory between two requesters:
- the pipeline MEM stage (core port, single-word accesses);
- a DMA/debug engine (burst port, 1..BURST_MAX consecutive words).

Core has priority. A starvation guard forces DMA in after MAX_WAIT blocked cycles. c_stall freezes the pipeline during DMA bursts. Sits between the MEM stage and the data memory instance.

---
 rtl/riscv_mem_pkg.sv | 13 +
 rtl/dmem_burst_ctr.sv | 47 ++++
 rtl/dmem_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the data-memory arbitration path: FSM state encoding
// and default bus widths.
package riscv_mem_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 32;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } arb_state_e;

endpackage

// File: rtl/dmem_burst_ctr.sv
// DMA burst beat counter: clamps the requested length, tracks the current beat
// and flags the final beat of a burst.
module dmem_burst_ctr #(
    parameter int BURST_MAX = 16,
    parameter int LEN_W     = $clog2(BURST_MAX) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic             i_adv,
    input  logic [LEN_W-1:0] i_len,
    output logic             o_single,
    output logic             o_last,
    output logic [LEN_W-1:0] o_beat
);

    logic [LEN_W-1:0] w_len_clamp;
    logic [LEN_W-1:0] r_len_q;
    logic [LEN_W-1:0] r_beat;

    // A zero length still moves one word; oversize lengths saturate.
    always_comb begin
        w_len_clamp = i_len;
        if (i_len == '0) begin
            w_len_clamp = LEN_W'(1);
        end else if (i_len > LEN_W'(BURST_MAX)) begin
            w_len_clamp = LEN_W'(BURST_MAX);
        end
    end

    assign o_single = (w_len_clamp == LEN_W'(1));
    assign o_last   = (r_beat == r_len_q - LEN_W'(1));
    assign o_beat   = r_beat;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_len_q <= '0;
            r_beat  <= '0;
        end else if (i_start) begin
            r_len_q <= w_len_clamp;
            r_beat  <= o_single ? '0 : LEN_W'(1);
        end else if (i_adv) begin
            r_beat  <= o_last ? '0 : r_beat + LEN_W'(1);
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter between the MEM-stage core port and a DMA burst port.
// Define DMEM_ARB_PERF_EN to add the perf_c_stall / perf_d_wait counters.
module dmem_arbiter
    import riscv_mem_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int BURST_MAX = 16,
    parameter int MAX_WAIT  = 8,
    parameter int LEN_W     = $clog2(BURST_MAX) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              c_req,
    input  logic              c_we,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic              c_gnt,
    output logic              c_stall,
    output logic              c_rvalid,
    output logic [DATA_W-1:0] c_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LEN_W-1:0]  d_len,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_done,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef DMEM_ARB_PERF_EN
    ,
    output logic [31:0]       perf_c_stall,
    output logic [31:0]       perf_d_wait
`endif
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    arb_state_e        r_state;
    arb_state_e        w_state_next;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic [ADDR_W-1:0] r_base_q;
    logic              r_we_q;
    logic              r_c_rvalid;
    logic [DATA_W-1:0] r_c_rdata;
    logic              r_d_rvalid;
    logic [DATA_W-1:0] r_d_rdata;
    logic              r_d_done;

    logic              w_start;
    logic              w_adv;
    logic              w_single;
    logic              w_last;
    logic [LEN_W-1:0]  w_beat;
    logic              w_wait_full;

    dmem_burst_ctr #(
        .BURST_MAX (BURST_MAX),
        .LEN_W     (LEN_W)
    ) u_burst_ctr (
        .clk      (clk),
        .rst      (rst),
        .i_start  (w_start),
        .i_adv    (w_adv),
        .i_len    (d_len),
        .o_single (w_single),
        .o_last   (w_last),
        .o_beat   (w_beat)
    );

    assign w_wait_full = (r_wait_cnt == WAIT_W'(MAX_WAIT));

    // Grants are gated by rst so nothing reaches memory while reset is held.
    always_comb begin
        w_state_next = r_state;
        c_gnt        = 1'b0;
        d_gnt        = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        w_start      = 1'b0;
        w_adv        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (rst && d_req && (!c_req || w_wait_full)) begin
                    d_gnt     = 1'b1;
                    w_start   = 1'b1;
                    mem_we    = d_we;
                    mem_addr  = d_addr;
                    mem_wdata = d_wdata;
                    if (!w_single) begin
                        w_state_next = ST_BURST;
                    end
                end else if (rst && c_req) begin
                    c_gnt     = 1'b1;
                    mem_we    = c_we;
                    mem_addr  = c_addr;
                    mem_wdata = c_wdata;
                end
            end
            ST_BURST: begin
                d_gnt     = 1'b1;
                w_adv     = 1'b1;
                mem_we    = r_we_q;
                mem_addr  = r_base_q + ADDR_W'(w_beat);
                mem_wdata = d_wdata;
                if (w_last) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign c_stall = rst && c_req && !c_gnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_wait_cnt <= '0;
            r_base_q   <= '0;
            r_we_q     <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_start) begin
                r_wait_cnt <= '0;
                r_base_q   <= d_addr;
                r_we_q     <= d_we;
            end else if (r_state == ST_IDLE && d_req && !d_gnt && !w_wait_full) begin
                r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
            end
        end
    end

    // Read data is captured into the owner's register in the grant cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_c_rvalid <= 1'b0;
            r_c_rdata  <= '0;
            r_d_rvalid <= 1'b0;
            r_d_rdata  <= '0;
            r_d_done   <= 1'b0;
        end else begin
            r_c_rvalid <= c_gnt && !mem_we;
            r_d_rvalid <= d_gnt && !mem_we;
            r_d_done   <= d_gnt && ((r_state == ST_IDLE) ? w_single : w_last);
            if (c_gnt && !mem_we) begin
                r_c_rdata <= mem_rdata;
            end
            if (d_gnt && !mem_we) begin
                r_d_rdata <= mem_rdata;
            end
        end
    end

    assign c_rvalid = r_c_rvalid;
    assign c_rdata  = r_c_rdata;
    assign d_rvalid = r_d_rvalid;
    assign d_rdata  = r_d_rdata;
    assign d_done   = r_d_done;

`ifdef DMEM_ARB_PERF_EN
    logic [31:0] r_perf_c_stall;
    logic [31:0] r_perf_d_wait;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_perf_c_stall <= '0;
            r_perf_d_wait  <= '0;
        end else begin
            if (c_stall && (r_perf_c_stall != '1)) begin
                r_perf_c_stall <= r_perf_c_stall + 32'd1;
            end
            if (d_req && !d_gnt && (r_perf_d_wait != '1)) begin
                r_perf_d_wait <= r_perf_d_wait + 32'd1;
            end
        end
    end

    assign perf_c_stall = r_perf_c_stall;
    assign perf_d_wait  = r_perf_d_wait;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed vector table, multi-cycle
// corner sequences and random traffic against a transaction-level model.
module tb_dmem_arbiter;

    localparam int ADDR_W    = 32;
    localparam int DATA_W    = 32;
    localparam int BURST_MAX = 16;
    localparam int MAX_WAIT  = 8;
    localparam int LEN_W     = 5;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              c_req, c_we;
    logic [ADDR_W-1:0] c_addr;
    logic [DATA_W-1:0] c_wdata;
    logic              c_gnt, c_stall, c_rvalid;
    logic [DATA_W-1:0] c_rdata;
    logic              d_req, d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [LEN_W-1:0]  d_len;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt, d_rvalid, d_done;
    logic [DATA_W-1:0] d_rdata;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
`ifdef DMEM_ARB_PERF_EN
    logic [31:0]       perf_c_stall, perf_d_wait;
`endif

    always #5 clk = ~clk;

    dmem_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .c_req     (c_req),
        .c_we      (c_we),
        .c_addr    (c_addr),
        .c_wdata   (c_wdata),
        .c_gnt     (c_gnt),
        .c_stall   (c_stall),
        .c_rvalid  (c_rvalid),
        .c_rdata   (c_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_len     (d_len),
        .d_wdata   (d_wdata),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .d_done    (d_done),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
`ifdef DMEM_ARB_PERF_EN
        .perf_c_stall (perf_c_stall),
        .perf_d_wait  (perf_d_wait),
`endif
        .mem_rdata (mem_rdata)
    );

    // Bench-side memory: combinational read, write at posedge, 256 words.
    logic [31:0] mem [256];
    logic        mem_clr = 1'b1;
    assign mem_rdata = mem[mem_addr[7:0]];
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= '0;
        end else if (mem_we) begin
            mem[mem_addr[7:0]] <= mem_wdata;
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: pending beats as a queue of addresses.
    logic [31:0] m_mem [256];
    logic [31:0] m_q [$];
    logic        m_bwe;
    int          m_wait;
    logic        m_started;
    logic        x_crv, x_drv, x_dd;
    logic [31:0] x_crd, x_drd;

    logic        s_c_gnt, s_d_gnt, s_c_stall, s_mem_we, s_c_rvalid, s_d_rvalid, s_d_done;
    logic [31:0] s_mem_addr, s_c_rdata, s_d_rdata;

    task automatic model_reset();
        m_q.delete();
        m_wait    = 0;
        m_bwe     = 1'b0;
        m_started = 1'b0;
        x_crv = 1'b0; x_drv = 1'b0; x_dd = 1'b0;
        x_crd = '0;   x_drd = '0;
    endtask

    task automatic model_step();
        logic        eg_c = 1'b0;
        logic        eg_d = 1'b0;
        logic        e_we = 1'b0;
        logic        last = 1'b0;
        logic [31:0] e_addr = '0;
        logic [31:0] e_wd = '0;
        int          n;
        m_started = 1'b0;
        if (m_q.size() > 0) begin
            eg_d   = 1'b1;
            e_addr = m_q.pop_front();
            e_we   = m_bwe;
            e_wd   = d_wdata;
            last   = (m_q.size() == 0);
        end else if (d_req && (!c_req || m_wait == MAX_WAIT)) begin
            n = (d_len == 0) ? 1 : ((int'(d_len) > BURST_MAX) ? BURST_MAX : int'(d_len));
            eg_d   = 1'b1;
            e_addr = d_addr;
            e_we   = d_we;
            e_wd   = d_wdata;
            m_bwe  = d_we;
            for (int k = 1; k < n; k++) m_q.push_back(d_addr + 32'(k));
            last      = (n == 1);
            m_wait    = 0;
            m_started = 1'b1;
        end else begin
            if (c_req) begin
                eg_c   = 1'b1;
                e_addr = c_addr;
                e_we   = c_we;
                e_wd   = c_wdata;
            end
            if (d_req && m_wait < MAX_WAIT) m_wait++;
        end
        chk("model c_gnt", c_gnt, eg_c);
        chk("model d_gnt", d_gnt, eg_d);
        chk("model c_stall", c_stall, c_req && !eg_c);
        chk("model mem_we", mem_we, e_we);
        chk("model mem_addr", mem_addr, e_addr);
        chk("model mem_wdata", mem_wdata, e_wd);
        chk("model c_rvalid", c_rvalid, x_crv);
        chk("model c_rdata", c_rdata, x_crd);
        chk("model d_rvalid", d_rvalid, x_drv);
        chk("model d_rdata", d_rdata, x_drd);
        chk("model d_done", d_done, x_dd);
        x_crv = eg_c && !e_we;
        if (x_crv) x_crd = m_mem[e_addr[7:0]];
        x_drv = eg_d && !e_we;
        if (x_drv) x_drd = m_mem[e_addr[7:0]];
        x_dd = eg_d && last;
        if ((eg_c || eg_d) && e_we) m_mem[e_addr[7:0]] = e_wd;
    endtask

    // Inputs are set at a negedge; outputs are sampled 1 ns later.
    task automatic step();
        #1;
        s_c_gnt = c_gnt;   s_d_gnt = d_gnt;       s_c_stall = c_stall;
        s_mem_we = mem_we; s_mem_addr = mem_addr;
        s_c_rvalid = c_rvalid; s_c_rdata = c_rdata;
        s_d_rvalid = d_rvalid; s_d_rdata = d_rdata; s_d_done = d_done;
        if (rst) model_step();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        c_req = 0; c_we = 0; c_addr = '0; c_wdata = '0;
        d_req = 0; d_we = 0; d_addr = '0; d_len = '0; d_wdata = '0;
    endtask

    typedef struct {
        logic c_req; logic c_we; logic [31:0] c_addr; logic [31:0] c_wdata;
        logic d_req; logic d_we; logic [31:0] d_addr; logic [4:0] d_len; logic [31:0] d_wdata;
        logic e_cg; logic e_dg; logic e_st; logic e_we; logic [31:0] e_addr;
        logic e_crv; logic [31:0] e_crd; logic e_drv; logic [31:0] e_drd; logic e_dd;
    } vec_t;

    vec_t tbl [19];
    int   cnt;

    initial begin
        // core write/read, DMA write x4, DMA read x3 with core stall, len 0, address wrap
        tbl[0]  = '{1,1,5,32'hDEADBEEF, 0,0,0,0,0,            1,0,0,1,5,            0,0,0,0,0};
        tbl[1]  = '{1,0,5,0,            0,0,0,0,0,            1,0,0,0,5,            0,0,0,0,0};
        tbl[2]  = '{0,0,0,0,            0,0,0,0,0,            0,0,0,0,0,            1,32'hDEADBEEF,0,0,0};
        tbl[3]  = '{0,0,0,0,            1,1,32'h10,4,1,       0,1,0,1,32'h10,       0,32'hDEADBEEF,0,0,0};
        tbl[4]  = '{0,0,0,0,            0,0,0,0,2,            0,1,0,1,32'h11,       0,32'hDEADBEEF,0,0,0};
        tbl[5]  = '{0,0,0,0,            0,0,0,0,3,            0,1,0,1,32'h12,       0,32'hDEADBEEF,0,0,0};
        tbl[6]  = '{0,0,0,0,            0,0,0,0,4,            0,1,0,1,32'h13,       0,32'hDEADBEEF,0,0,0};
        tbl[7]  = '{0,0,0,0,            0,0,0,0,0,            0,0,0,0,0,            0,32'hDEADBEEF,0,0,1};
        tbl[8]  = '{0,0,0,0,            0,0,0,0,0,            0,0,0,0,0,            0,32'hDEADBEEF,0,0,0};
        tbl[9]  = '{0,0,0,0,            1,0,32'h10,3,0,       0,1,0,0,32'h10,       0,32'hDEADBEEF,0,0,0};
        tbl[10] = '{1,0,32'h12,0,       0,0,0,0,0,            0,1,1,0,32'h11,       0,32'hDEADBEEF,1,1,0};
        tbl[11] = '{1,0,32'h12,0,       0,0,0,0,0,            0,1,1,0,32'h12,       0,32'hDEADBEEF,1,2,0};
        tbl[12] = '{1,0,32'h12,0,       0,0,0,0,0,            1,0,0,0,32'h12,       0,32'hDEADBEEF,1,3,1};
        tbl[13] = '{0,0,0,0,            0,0,0,0,0,            0,0,0,0,0,            1,3,0,3,0};
        tbl[14] = '{0,0,0,0,            1,1,32'h20,0,32'hAA,  0,1,0,1,32'h20,       0,3,0,3,0};
        tbl[15] = '{0,0,0,0,            0,0,0,0,0,            0,0,0,0,0,            0,3,0,3,1};
        tbl[16] = '{0,0,0,0,            1,1,32'hFFFFFFFF,2,7, 0,1,0,1,32'hFFFFFFFF, 0,3,0,3,0};
        tbl[17] = '{0,0,0,0,            0,0,0,0,8,            0,1,0,1,0,            0,3,0,3,0};
        tbl[18] = '{0,0,0,0,            0,0,0,0,0,            0,0,0,0,0,            0,3,0,3,1};

        foreach (m_mem[i]) m_mem[i] = '0;
        model_reset();
        idle_inputs();
        d_req = 1; d_len = 4;
        c_req = 1;
        repeat (3) @(negedge clk);
        #1;
        chk("reset c_gnt", c_gnt, 0);
        chk("reset d_gnt", d_gnt, 0);
        chk("reset c_stall", c_stall, 0);
        chk("reset mem_addr", mem_addr, 0);
        chk("reset c_rvalid", c_rvalid, 0);
        chk("reset d_done", d_done, 0);
        @(negedge clk);
        idle_inputs();
        mem_clr = 1'b0;
        rst = 1'b1;
        $display("reset released");

        for (int i = 0; i < 19; i++) begin
            c_req = tbl[i].c_req; c_we = tbl[i].c_we; c_addr = tbl[i].c_addr; c_wdata = tbl[i].c_wdata;
            d_req = tbl[i].d_req; d_we = tbl[i].d_we; d_addr = tbl[i].d_addr; d_len = tbl[i].d_len;
            d_wdata = tbl[i].d_wdata;
            step();
            $display("vec %0d: c_gnt=%0d d_gnt=%0d addr=%h d_done=%0d", i, s_c_gnt, s_d_gnt, s_mem_addr, s_d_done);
            chk($sformatf("vec%0d c_gnt", i), s_c_gnt, tbl[i].e_cg);
            chk($sformatf("vec%0d d_gnt", i), s_d_gnt, tbl[i].e_dg);
            chk($sformatf("vec%0d c_stall", i), s_c_stall, tbl[i].e_st);
            chk($sformatf("vec%0d mem_we", i), s_mem_we, tbl[i].e_we);
            chk($sformatf("vec%0d mem_addr", i), s_mem_addr, tbl[i].e_addr);
            chk($sformatf("vec%0d c_rvalid", i), s_c_rvalid, tbl[i].e_crv);
            chk($sformatf("vec%0d c_rdata", i), s_c_rdata, tbl[i].e_crd);
            chk($sformatf("vec%0d d_rvalid", i), s_d_rvalid, tbl[i].e_drv);
            chk($sformatf("vec%0d d_rdata", i), s_d_rdata, tbl[i].e_drd);
            chk($sformatf("vec%0d d_done", i), s_d_done, tbl[i].e_dd);
        end
        for (int i = 0; i < 4; i++) chk($sformatf("mem[0x1%0d]", i), mem[16 + i], 32'(i + 1));
        chk("mem[0x20]", mem[32], 32'hAA);
        chk("mem[wrap 0]", mem[0], 32'd8);
        idle_inputs();

        // Contention: core held, DMA forced in after MAX_WAIT blocked cycles.
        c_req = 1; c_addr = 1;
        d_req = 1; d_we = 1; d_addr = 32'h40; d_len = 4;
        for (int i = 0; i < 13; i++) begin
            d_wdata = $urandom;
            step();
            if (m_started) d_req = 0;
            if (i < MAX_WAIT) begin
                chk($sformatf("contend c_gnt cyc%0d", i), s_c_gnt, 1);
                chk($sformatf("contend d_gnt cyc%0d", i), s_d_gnt, 0);
            end else if (i < MAX_WAIT + 4) begin
                chk($sformatf("contend d_gnt cyc%0d", i), s_d_gnt, 1);
                chk($sformatf("contend c_stall cyc%0d", i), s_c_stall, 1);
            end else begin
                chk("contend core regain", s_c_gnt, 1);
            end
        end
        $display("contention sequence: core starved DMA for %0d cycles", MAX_WAIT);
        idle_inputs();

        // Oversize length clamps to BURST_MAX beats.
        cnt = 0;
        d_req = 1; d_we = 0; d_addr = 32'h80; d_len = 31;
        for (int i = 0; i < 20; i++) begin
            step();
            if (m_started) d_req = 0;
            if (s_d_gnt) cnt++;
        end
        chk("len31 beat count", cnt, BURST_MAX);
        $display("len31 burst: %0d beats", cnt);

        // Reset asserted during beat 2 of a 4-beat write burst.
        d_req = 1; d_we = 1; d_addr = 32'h60; d_len = 4; d_wdata = 32'h600;
        step();
        d_req = 0; d_wdata = 32'h601;
        step();
        rst = 0; c_req = 1; c_addr = 5;
        #1;
        chk("midrst d_gnt", d_gnt, 0);
        chk("midrst c_gnt", c_gnt, 0);
        chk("midrst c_stall", c_stall, 0);
        chk("midrst mem_we", mem_we, 0);
        chk("midrst mem_addr", mem_addr, 0);
        chk("midrst d_rvalid", d_rvalid, 0);
        chk("midrst d_done", d_done, 0);
        @(negedge clk);
        #1;
        chk("midrst d_done held", d_done, 0);
        @(negedge clk);
        rst = 1;
        model_reset();
        step();
        chk("post-reset core grant", s_c_gnt, 1);
        c_req = 0;
        step();
        chk("post-reset c_rvalid", s_c_rvalid, 1);
        chk("post-reset c_rdata", s_c_rdata, 32'hDEADBEEF);
        chk("beat1 before reset written", mem[8'h61], 32'h601);
        $display("reset mid-burst sequence done");
        idle_inputs();

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            if (!d_req && $urandom_range(0, 5) == 0) begin
                d_req  = 1;
                d_we   = 1'($urandom);
                d_addr = ($urandom_range(0, 7) == 0) ? (32'hFFFFFFF0 + 32'($urandom_range(0, 15)))
                                                      : 32'($urandom_range(0, 255));
                d_len  = 5'($urandom_range(0, 31));
            end
            d_wdata = $urandom;
            c_req   = ($urandom_range(0, 9) < 6);
            c_we    = 1'($urandom);
            c_addr  = 32'($urandom_range(0, 255));
            c_wdata = $urandom;
            step();
            if (m_started) begin
                $display("rand burst %0d: addr=%h len=%0d we=%0d", i, d_addr, d_len, d_we);
                d_req = 0;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
